// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and helpers for the nibble serial transmitter.
package nibble_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    // Counter width for a count of n values, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_tx_if.sv
// FIFO read-port bundle between a show-ahead FIFO and its consumer.
// master = consumer (issues pops), slave = FIFO (supplies flag and data).
interface nibble_serial_tx_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_read_en;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_read_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_read_en
    );
endinterface

// File: rtl/nibble_serial_tx_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while run is high and flags the
// last cycle of each bit. With BIT_CYCLES=1 the count stays at zero and
// bit_done simply follows run.
module bit_period_timer
    import nibble_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_done
);
    localparam int             TW   = min1_clog2(BIT_CYCLES);
    localparam logic [TW-1:0]  LAST = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] count;

    assign bit_done = run && (count == LAST);

    // Count within a bit; restart at the bit boundary and hold at zero when idle.
    always_ff @(posedge clk) begin
        if (rst || !run || bit_done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/nibble_serial_tx.sv
// Pops nibbles from a show-ahead FIFO and sends each as a serial frame:
// start bit, data LSB first, optional even parity, stop bit.
module nibble_serial_tx
    import nibble_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    nibble_serial_tx_if.master    fifo_if,
    output logic                  tx,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_sent
);
    localparam int                IDX_W    = min1_clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    parity_q, parity_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_WIDTH-1:0]    frames_d;
    logic                    tx_d;
    logic                    busy_d;
    logic                    bit_done;
    logic                    pop;

    assign pop = (state_q == IDLE) && enable && !fifo_if.fifo_empty && !rst;

    bit_period_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q != IDLE),
        .bit_done (bit_done)
    );

    // State, datapath and registered line outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            idx_q       <= '0;
            frames_sent <= '0;
            tx          <= TX_IDLE_LEVEL;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            idx_q       <= idx_d;
            frames_sent <= frames_d;
            tx          <= tx_d;
            busy        <= busy_d;
        end
    end

    // Next state: advance one frame field per completed bit period.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        frames_d = frames_sent;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d  = START;
                    shreg_d  = fifo_if.fifo_rdata;
                    parity_d = ^fifo_if.fifo_rdata;
                    idx_d    = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d  = IDLE;
                    frames_d = frames_sent + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pop strobe, plus line level and busy for the state being entered.
    always_comb begin
        fifo_if.fifo_read_en = pop;
        busy_d               = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[idx_d];
            PARITY:  tx_d = parity_d;
            default: tx_d = TX_IDLE_LEVEL;
        endcase
    end
endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench: instance a (BIT_CYCLES=4, parity on, 16-bit counter) and
// instance b (BIT_CYCLES=4, parity off, 2-bit counter for wrap).
module tb_nibble_serial_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_a = 1'b1;
    logic        enable_b = 1'b0;
    logic        tx_a, busy_a, tx_b, busy_b;
    logic [15:0] frames_a;
    logic [1:0]  frames_b;

    logic [3:0]  q_a[$];
    logic [3:0]  q_b[$];
    int          pops_a = 0;
    int          pops_b = 0;
    int          total = 0;
    int          bad = 0;
    int          w;
    int          p0;

    nibble_serial_tx_if #(.DATA_WIDTH(4)) fa ();
    nibble_serial_tx_if #(.DATA_WIDTH(4)) fb ();

    nibble_serial_tx #(
        .DATA_WIDTH(4), .BIT_CYCLES(4), .PARITY_EN(1), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .fifo_if(fa.master),
        .tx(tx_a), .busy(busy_a), .frames_sent(frames_a)
    );

    nibble_serial_tx #(
        .DATA_WIDTH(4), .BIT_CYCLES(4), .PARITY_EN(0), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .fifo_if(fb.master),
        .tx(tx_b), .busy(busy_b), .frames_sent(frames_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic refresh();
        fa.fifo_empty = (q_a.size() == 0);
        fa.fifo_rdata = (q_a.size() != 0) ? q_a[0] : 4'h0;
        fb.fifo_empty = (q_b.size() == 0);
        fb.fifo_rdata = (q_b.size() != 0) ? q_b[0] : 4'h0;
    endtask

    task automatic push(input int sel, input logic [3:0] v);
        if (sel == 0) q_a.push_back(v);
        else          q_b.push_back(v);
        refresh();
    endtask

    always @(negedge clk) refresh();

    // FIFO model: pop on the edge where the strobe is seen.
    always @(posedge clk) begin
        if (fa.fifo_read_en) begin
            check("pop_a_nonempty", fa.fifo_empty, 1'b0);
            if (q_a.size() != 0) void'(q_a.pop_front());
            pops_a++;
        end
        if (fb.fifo_read_en) begin
            check("pop_b_nonempty", fb.fifo_empty, 1'b0);
            if (q_b.size() != 0) void'(q_b.pop_front());
            pops_b++;
        end
    end

    // Wait (bounded) for a pop strobe; returns at negedge+1 of the pop cycle.
    task automatic wait_pop(input int sel, output int waited);
        waited = 0;
        #1;
        while (((sel == 0) ? fa.fifo_read_en : fb.fifo_read_en) !== 1'b1 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 200) check("pop_timeout", 0, 1);
    endtask

    // Check a whole frame cycle by cycle, then the idle cycle after it.
    task automatic expect_frame(input int sel, input logic [3:0] nib, input int drop_at,
                                output int waited);
        logic bits [0:6];
        int   k;
        int   cyc;
        wait_pop(sel, waited);
        if (waited >= 200) return;
        k = 0;
        bits[k] = 1'b0; k = k + 1;
        for (int i = 0; i < 4; i++) begin
            bits[k] = nib[i]; k = k + 1;
        end
        if (sel == 0) begin
            bits[k] = ^nib; k = k + 1;
        end
        bits[k] = 1'b1; k = k + 1;
        cyc = 0;
        for (int i = 0; i < k; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("tx", (sel == 0) ? tx_a : tx_b, bits[i]);
                check("busy", (sel == 0) ? busy_a : busy_b, 1'b1);
                if (cyc == drop_at) begin
                    if (sel == 0) enable_a = 1'b0;
                    else          enable_b = 1'b0;
                end
                cyc++;
            end
        end
        @(negedge clk);
        check("tx_idle", (sel == 0) ? tx_a : tx_b, 1'b1);
        check("busy_end", (sel == 0) ? busy_a : busy_b, 1'b0);
    endtask

    initial begin
        // 1: reset held with a non-empty FIFO
        push(0, 4'hA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_tx", tx_a, 1'b1);
            check("rst_busy", busy_a, 1'b0);
            check("rst_frames", frames_a, 16'd0);
            check("rst_pop", fa.fifo_read_en, 1'b0);
        end
        rst = 1'b0;

        // 2: 0xA with parity -> 0,0,1,0,1,0,1
        expect_frame(0, 4'hA, -1, w);
        check("frames_a_1", frames_a, 16'd1);
        check("pops_a_1", pops_a, 1);

        // 3: 0x7 parity 1 on a; 24-cycle frame on b, then b counter wrap
        push(0, 4'h7);
        expect_frame(0, 4'h7, -1, w);
        check("frames_a_2", frames_a, 16'd2);
        enable_b = 1'b1;
        push(1, 4'h7);
        expect_frame(1, 4'h7, -1, w);
        check("frames_b_1", frames_b, 2'd1);
        push(1, 4'h0);
        push(1, 4'hF);
        push(1, 4'h8);
        expect_frame(1, 4'h0, -1, w);
        check("gap_b_1", w, 0);
        expect_frame(1, 4'hF, -1, w);
        check("gap_b_2", w, 0);
        check("frames_b_3", frames_b, 2'd3);
        expect_frame(1, 4'h8, -1, w);
        check("gap_b_3", w, 0);
        check("frames_b_wrap", frames_b, 2'd0);
        enable_b = 1'b0;

        // 4: three queued nibbles back to back
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("frames_a_rst", frames_a, 16'd0);
        p0 = pops_a;
        push(0, 4'h3);
        push(0, 4'hC);
        push(0, 4'hF);
        expect_frame(0, 4'h3, -1, w);
        expect_frame(0, 4'hC, -1, w);
        check("gap_a_1", w, 0);
        expect_frame(0, 4'hF, -1, w);
        check("gap_a_2", w, 0);
        check("frames_a_3", frames_a, 16'd3);
        repeat (6) @(negedge clk);
        #1;
        check("empty_no_pop", fa.fifo_read_en, 1'b0);
        check("pops_a_3", pops_a - p0, 3);
        check("idle_busy", busy_a, 1'b0);

        // 5: enable dropped in cycle 5 of a frame with two queued
        p0 = pops_a;
        push(0, 4'h5);
        push(0, 4'h9);
        expect_frame(0, 4'h5, 4, w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("disabled_no_pop", fa.fifo_read_en, 1'b0);
        end
        check("pops_disabled", pops_a - p0, 1);
        @(negedge clk);
        enable_a = 1'b1;
        #1;
        check("pop_on_enable", fa.fifo_read_en, 1'b1);
        expect_frame(0, 4'h9, -1, w);
        check("pop_on_enable_wait", w, 0);
        check("frames_a_5", frames_a, 16'd5);

        // 6: reset during data bit d2 of 0xB; 0xC follows intact
        push(0, 4'hB);
        push(0, 4'hC);
        wait_pop(0, w);
        repeat (13) @(negedge clk);
        check("d2_tx", tx_a, 1'b0);
        check("d2_busy", busy_a, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_tx", tx_a, 1'b1);
        check("abort_busy", busy_a, 1'b0);
        check("abort_frames", frames_a, 16'd0);
        check("abort_pop", fa.fifo_read_en, 1'b0);
        rst = 1'b0;
        expect_frame(0, 4'hC, -1, w);
        check("after_rst_wait", w, 0);
        check("frames_a_after_rst", frames_a, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
